// File: rtl/switch_pkg.sv
// Shared definitions for the switch debouncer.
//   NUM_SWITCHES : number of board switches handled by the block
//   switch_vec_t : one bit per switch
package switch_pkg;

   localparam int NUM_SWITCHES = 8;

   typedef logic [NUM_SWITCHES-1:0] switch_vec_t;

endpackage : switch_pkg

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchronizer, stability counter and optional
// edge pulses.
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   sw_async : raw bouncing switch level
//   clean    : debounced level (registered)
//   rise     : one-cycle pulse on an accepted 0->1 change
//   fall     : one-cycle pulse on an accepted 1->0 change
// Optional macro SWITCH_EDGE_PULSE_EN: when undefined, rise/fall are tied
// to 0 and no edge flops exist.
module switch_debounce_bit #(
   parameter int STABLE_CYCLES = 50000,
   parameter int COUNT_W       = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_async,
   output logic clean,
   output logic rise,
   output logic fall
);

   // Terminal count; STABLE_CYCLES <= 2**COUNT_W keeps this representable.
   localparam logic [COUNT_W-1:0] LAST = COUNT_W'(STABLE_CYCLES - 1);

   logic               sync1_q, sync2_q;
   logic [COUNT_W-1:0] cnt_q, cnt_d;
   logic               clean_q, clean_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
      end else begin
         sync1_q <= sw_async;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
      end
   end

   // Counter runs only while the synchronized level disagrees with the
   // accepted level; any agreement (a bounce back) restarts it from zero.
   always_comb begin
      cnt_d   = '0;
      clean_d = clean_q;
      if (sync2_q != clean_q) begin
         if (cnt_q == LAST) begin
            clean_d = sync2_q;
         end else begin
            cnt_d = cnt_q + COUNT_W'(1);
         end
      end
   end

   assign clean = clean_q;

`ifdef SWITCH_EDGE_PULSE_EN
   logic rise_q, fall_q;

   // Registered alongside clean_q so the pulse coincides with the update.
   always_ff @(posedge clk) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= clean_d & ~clean_q;
         fall_q <= ~clean_d & clean_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule : switch_debounce_bit

// File: rtl/switch_debouncer.sv
// Debouncer for NUM_SWITCHES independent board switches.
//   clk      : clock, all state on rising edge
//   rst      : synchronous active-high reset
//   switch   : raw asynchronous bouncing switches
//   sw_clean : debounced levels, registered
//   sw_rise  : per-bit one-cycle pulse on accepted 0->1
//   sw_fall  : per-bit one-cycle pulse on accepted 1->0
// Parameters: STABLE_CYCLES (1 .. 2**COUNT_W), COUNT_W.
// Optional macro SWITCH_EDGE_PULSE_EN enables sw_rise/sw_fall; otherwise
// they are constant 0.
// Latency from a clean switch edge to sw_clean is 2 + STABLE_CYCLES.
module switch_debouncer
   import switch_pkg::*;
#(
   parameter int STABLE_CYCLES = 50000,
   parameter int COUNT_W       = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_SWITCHES-1:0] switch,
   output logic [NUM_SWITCHES-1:0] sw_clean,
   output logic [NUM_SWITCHES-1:0] sw_rise,
   output logic [NUM_SWITCHES-1:0] sw_fall
);

   switch_vec_t clean_w, rise_w, fall_w;

   for (genvar i = 0; i < NUM_SWITCHES; i++) begin : g_bit
      switch_debounce_bit #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .COUNT_W       (COUNT_W)
      ) u_bit (
         .clk      (clk),
         .rst      (rst),
         .sw_async (switch[i]),
         .clean    (clean_w[i]),
         .rise     (rise_w[i]),
         .fall     (fall_w[i])
      );
   end

   assign sw_clean = clean_w;
   assign sw_rise  = rise_w;
   assign sw_fall  = fall_w;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] switch = 8'h00;
   logic [7:0] sw_clean, sw_rise, sw_fall;

   int checks = 0;
   int errors = 0;

   switch_debouncer #(.STABLE_CYCLES(4), .COUNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .switch   (switch),
      .sw_clean (sw_clean),
      .sw_rise  (sw_rise),
      .sw_fall  (sw_fall)
   );

   always #5 clk = ~clk;

   // Pulses exist only in the edge-pulse build; otherwise they must be 0.
   function automatic logic [7:0] pmask(input logic [7:0] m);
`ifdef SWITCH_EDGE_PULSE_EN
      return m;
`else
      return 8'h00;
`endif
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; switch = 8'hA5;
      step(3);
      checks++; if (sw_clean !== 8'h00) begin errors++; $display("FAIL reset_clean got %h exp 00", sw_clean); end
      checks++; if (sw_rise  !== 8'h00) begin errors++; $display("FAIL reset_rise got %h exp 00", sw_rise); end
      checks++; if (sw_fall  !== 8'h00) begin errors++; $display("FAIL reset_fall got %h exp 00", sw_fall); end
      switch = 8'h00;
      step(1);
      rst = 1'b0;
      step(8);
   endtask

   // switch=01 steady: accepted exactly 6 cycles later with a single rise.
   task automatic test_single_rise;
      switch = 8'h01;
      step(5);
      checks++; if (sw_clean !== 8'h00) begin errors++; $display("FAIL rise_early got %h exp 00", sw_clean); end
      checks++; if (sw_rise !== 8'h00) begin errors++; $display("FAIL rise_early_pulse got %h exp 00", sw_rise); end
      step(1);
      checks++; if (sw_clean !== 8'h01) begin errors++; $display("FAIL rise_clean got %h exp 01", sw_clean); end
      checks++; if (sw_rise !== pmask(8'h01)) begin errors++; $display("FAIL rise_pulse got %h exp %h", sw_rise, pmask(8'h01)); end
      checks++; if (sw_fall !== 8'h00) begin errors++; $display("FAIL rise_nofall got %h exp 00", sw_fall); end
      step(1);
      checks++; if (sw_rise !== 8'h00) begin errors++; $display("FAIL rise_one_cycle got %h exp 00", sw_rise); end
      checks++; if (sw_clean !== 8'h01) begin errors++; $display("FAIL rise_hold got %h exp 01", sw_clean); end
   endtask

   // bit 3 bounces 1,0,1 then holds; only one rise, 6 cycles after last edge.
   task automatic test_bounce;
      int bad = 0;
      switch = 8'h09; step(1);
      switch = 8'h01; step(1);
      switch = 8'h09;
      for (int k = 0; k < 5; k++) begin
         step(1);
         if (sw_clean !== 8'h01 || sw_rise !== 8'h00) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL bounce_early got %0d bad cycles exp 0", bad); end
      step(1);
      checks++; if (sw_clean !== 8'h09) begin errors++; $display("FAIL bounce_clean got %h exp 09", sw_clean); end
      checks++; if (sw_rise !== pmask(8'h08)) begin errors++; $display("FAIL bounce_pulse got %h exp %h", sw_rise, pmask(8'h08)); end
      step(1);
      checks++; if (sw_rise !== 8'h00) begin errors++; $display("FAIL bounce_one_cycle got %h exp 00", sw_rise); end
   endtask

   // bit 5 high for 3 synchronized cycles only: discarded (one short of 4).
   task automatic test_glitch;
      int bad = 0;
      switch = 8'h29; step(3);
      switch = 8'h09;
      for (int k = 0; k < 10; k++) begin
         step(1);
         if (sw_clean !== 8'h09 || sw_rise !== 8'h00 || sw_fall !== 8'h00) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL glitch got %0d bad cycles exp 0", bad); end
   endtask

   // All ones, then all bits drop at once.
   task automatic test_all_fall;
      switch = 8'hFF; step(6);
      checks++; if (sw_clean !== 8'hFF) begin errors++; $display("FAIL ff_clean got %h exp FF", sw_clean); end
      checks++; if (sw_rise !== pmask(8'hF6)) begin errors++; $display("FAIL ff_rise got %h exp %h", sw_rise, pmask(8'hF6)); end
      step(2);
      switch = 8'h00; step(5);
      checks++; if (sw_clean !== 8'hFF) begin errors++; $display("FAIL fall_early got %h exp FF", sw_clean); end
      step(1);
      checks++; if (sw_clean !== 8'h00) begin errors++; $display("FAIL fall_clean got %h exp 00", sw_clean); end
      checks++; if (sw_fall !== pmask(8'hFF)) begin errors++; $display("FAIL fall_pulse got %h exp %h", sw_fall, pmask(8'hFF)); end
      checks++; if (sw_rise !== 8'h00) begin errors++; $display("FAIL fall_norise got %h exp 00", sw_rise); end
      step(1);
      checks++; if (sw_fall !== 8'h00) begin errors++; $display("FAIL fall_one_cycle got %h exp 00", sw_fall); end
   endtask

   // Reset while bit 0 counter is 2: pending change dropped, count restarts.
   task automatic test_mid_reset;
      switch = 8'h01; step(4);
      rst = 1'b1; step(1);
      checks++; if (sw_clean !== 8'h00 || sw_rise !== 8'h00 || sw_fall !== 8'h00) begin
         errors++; $display("FAIL midrst_out got %h/%h/%h exp 00/00/00", sw_clean, sw_rise, sw_fall); end
      rst = 1'b0;
      step(5);
      checks++; if (sw_clean !== 8'h00) begin errors++; $display("FAIL midrst_early got %h exp 00", sw_clean); end
      step(1);
      checks++; if (sw_clean !== 8'h01) begin errors++; $display("FAIL midrst_clean got %h exp 01", sw_clean); end
      checks++; if (sw_rise !== pmask(8'h01)) begin errors++; $display("FAIL midrst_pulse got %h exp %h", sw_rise, pmask(8'h01)); end
   endtask

   // Switch held high through reset: normal rise 6 cycles after release.
   task automatic test_held_through_reset;
      switch = 8'h81;
      rst = 1'b1; step(3);
      checks++; if (sw_clean !== 8'h00) begin errors++; $display("FAIL held_rst got %h exp 00", sw_clean); end
      rst = 1'b0;
      step(5);
      checks++; if (sw_clean !== 8'h00) begin errors++; $display("FAIL held_early got %h exp 00", sw_clean); end
      step(1);
      checks++; if (sw_clean !== 8'h81) begin errors++; $display("FAIL held_clean got %h exp 81", sw_clean); end
      checks++; if (sw_rise !== pmask(8'h81)) begin errors++; $display("FAIL held_pulse got %h exp %h", sw_rise, pmask(8'h81)); end
   endtask

   initial begin
      test_reset;
      test_single_rise;
      test_bounce;
      test_glitch;
      test_all_fall;
      test_mid_reset;
      test_held_through_reset;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_switch_debouncer
